// File: rtl/seq_nonrestoring_divider.sv
// Iterative non-restoring divider with valid/ready handshakes, one quotient bit per cycle.
// Optional macro SIGNED_DIV_EN adds an sgn input for two's-complement truncating division.
module seq_nonrestoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] D,
  input  logic [DIVISOR_W-1:0]  M,
`ifdef SIGNED_DIV_EN
  input  logic                  sgn,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  div_by_zero
);

  localparam int PW = DIVISOR_W + 1;
  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [DIVIDEND_W-1:0] ONE_D = DIVIDEND_W'(1);
  localparam logic [DIVISOR_W-1:0]  ONE_M = DIVISOR_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, CORRECT, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] d_q, d_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  m_q, m_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic [PW-1:0]         p_q, p_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dbz_q, dbz_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;

  logic                  d_neg, m_neg;
  logic [DIVIDEND_W-1:0] d_mag;
  logic [DIVISOR_W-1:0]  m_mag;
  logic [PW-1:0]         m_ext, p_shift, p_step;
  logic [DIVISOR_W-1:0]  rem;

`ifdef SIGNED_DIV_EN
  assign d_neg = sgn & D[DIVIDEND_W-1];
  assign m_neg = sgn & M[DIVISOR_W-1];
`else
  assign d_neg = 1'b0;
  assign m_neg = 1'b0;
`endif

  // The core always divides magnitudes; signs are re-applied in CORRECT.
  assign d_mag = d_neg ? (~D + ONE_D) : D;
  assign m_mag = m_neg ? (~M + ONE_M) : M;

  // P wraps on the shift, but after the add/subtract it is back in [-M, M).
  assign m_ext   = {1'b0, m_q};
  assign p_shift = {p_q[PW-2:0], d_q[DIVIDEND_W-1]};
  assign p_step  = p_q[PW-1] ? (p_shift + m_ext) : (p_shift - m_ext);
  assign rem     = p_q[PW-1] ? (p_q[DIVISOR_W-1:0] + m_q) : p_q[DIVISOR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      m_q     <= m_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    m_d     = m_q;
    r_d     = r_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          d_d    = d_mag;
          m_d    = m_mag;
          p_d    = '0;
          r_d    = '0;
          cnt_d  = CW'(DIVIDEND_W - 1);
          qneg_d = d_neg ^ m_neg;
          rneg_d = d_neg;
          if (M == '0) begin
            q_d     = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        p_d = p_step;
        d_d = {d_q[DIVIDEND_W-2:0], 1'b0};
        q_d = {q_q[DIVIDEND_W-2:0], ~p_step[PW-1]};
        if (cnt_q == '0) begin
          state_d = CORRECT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      CORRECT: begin
        q_d     = qneg_q ? (~q_q + ONE_D) : q_q;
        r_d     = rneg_q ? (~rem + ONE_M) : rem;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_nonrestoring_divider.md
Name: seq_nonrestoring_divider

Overview:
- Parametrised, iterative non-restoring divider; successor to the fixed 7-bit/4-bit combinational CAS-array divider.
- Reuses one add/subtract stage over DIVIDEND_W cycles, producing one quotient bit per cycle, then does a final remainder-correction cycle.
- Uses valid/ready handshakes on input and output, so it sits directly in the datapath of the arithmetic unit.

Parameters:
DIVIDEND_W  8  dividend and quotient width; must be >= DIVISOR_W
DIVISOR_W   4  divisor and remainder width; must be >= 2

Ports:
clk          input   1            rising-edge clock
rst_n        input   1            asynchronous active-low reset
in_valid     input   1            operands valid
in_ready     output  1            divider can accept operands
D            input   DIVIDEND_W   dividend
M            input   DIVISOR_W    divisor
out_valid    output  1            result valid
out_ready    input   1            consumer accepts result
Q            output  DIVIDEND_W   quotient
R            output  DIVISOR_W    remainder
div_by_zero  output  1            result is from M == 0; qualified by out_valid

Behaviour:
- Reset (asynchronous, any state including mid-division):
  - State goes to IDLE; operation abandoned, no result produced.
  - in_ready=1, out_valid=0, Q=0, R=0, div_by_zero=0.
- FSM states: IDLE, RUN, CORRECT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture D and M; clear partial remainder P (DIVISOR_W+1 bits, two's complement); counter=DIVIDEND_W-1.
  - If M==0, go straight to DONE with Q=all ones, R=0, div_by_zero=1 (latency 1 cycle).
  - Otherwise go to RUN.
- RUN, one iteration per cycle for DIVIDEND_W cycles, dividend consumed MSB first:
  - Shift P left, bringing in the next dividend bit.
  - If previous P >= 0, P = P - M; else P = P + M.
  - Quotient bit = ~P[msb] after the operation, shifted into Q LSB.
  - When counter==0, go to CORRECT; else decrement the counter.
- CORRECT, 1 cycle:
  - If P < 0, R = P + M; else R = P. Truncate to DIVISOR_W bits.
  - Go to DONE.
- DONE:
  - out_valid=1. Q, R, div_by_zero are held stable while out_valid&~out_ready.
  - On out_ready, go to IDLE. out_valid falls and in_ready rises on the next cycle; there is no same-cycle re-accept.
- in_ready=0 in RUN, CORRECT and DONE. in_valid is ignored there and the operands are not latched.
- Latency: out_valid rises DIVIDEND_W+2 cycles after the accepting edge (1 cycle for M==0). Throughput is one division per DIVIDEND_W+3 cycles minimum.
- Results satisfy D = Q*M + R with 0 <= R < M (unsigned mode).
- Q and R registers are internal working registers during RUN. Consumers sample Q and R only when out_valid=1.

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined:
  - Adds input port sgn (1 bit), sampled with the operands.
  - sgn=1 treats D and M as two's complement. Division uses magnitudes; Q is negated if the signs differ; R takes the sign of D (truncating division).
  - Sign fix-up happens inside the CORRECT cycle, so latency is unchanged.
  - Overflow case (most-negative D / -1): Q=most-negative value, R=0, div_by_zero=0.
  - sgn=0 gives unsigned behaviour.
- Undefined: no sgn port; unsigned only.

Test Plan:
- Unsigned defaults, D=100, M=7 -> after 10 cycles out_valid=1, Q=14, R=2, div_by_zero=0.
- Boundary values:
  - D=255, M=1 -> Q=255, R=0.
  - D=5, M=15 -> Q=0, R=5.
  - D=0, M=9 -> Q=0, R=0.
- Divide by zero, D=0x5A, M=0 -> out_valid 1 cycle after accept, Q=0xFF, R=0, div_by_zero=1.
- Back-pressure: hold out_ready=0 for 5 cycles after D=200, M=13.
  - Q=15, R=5 stay stable and in_ready stays 0.
  - A new in_valid during this time is ignored.
  - After the out_ready pulse, the next operands are accepted.
- Reset mid-RUN: assert rst_n=0 on the 4th RUN cycle.
  - Outputs clear immediately and in_ready=1 after release.
  - A fresh D=100, M=7 gives Q=14, R=2.
- SIGNED_DIV_EN with sgn=1:
  - D=0x9C (-100), M=4'h7 -> Q=0xF2 (-14), R=4'hE (-2).
  - D=0x80, M=4'hF -> Q=0x80, R=0.
